adder_result_presenter: RTL
===========================

Name: adder_result_presenter

Overview:
- Output-side counterpart of the pushbutton operand loader in the seven-bit adder lab.
- Accepts one adder result (8-bit sum, 6-bit internal carry vector, carry-out) over a valid/ready handshake and shows it on 8 board LEDs.
- The user steps through display pages with a single raw pushbutton.
- Contains its own synchroniser/debouncer and a page-sequencing FSM.

Parameters:
- SUM_W, 8, width of sum input and LED bus.
- CARRY_W, 6, width of internal carry vector; must be <= SUM_W-1.
- DEBOUNCE_CYCLES, 16, consecutive stable cycles before the debounced button level changes; must be >= 1.
- AUTO_CYCLES, 1000000, auto-advance dwell in cycles; used only with AUTO_ADV_EN.

Ports:
- clk  input  1  single system clock; all state on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  result present on in_sum/in_carry/in_cout.
- in_ready  output  1  presenter can accept a result.
- in_sum  input  SUM_W  adder sum.
- in_carry  input  CARRY_W  internal carry vector.
- in_cout  input  1  adder carry-out.
- pb_next  input  1  raw, asynchronous, bouncing pushbutton; 1 = pressed.
- led  output  SUM_W  LED drive.
- phase  output  2  current page: 00 IDLE, 01 SUM, 10 CARRY.
- busy  output  1  high whenever phase != IDLE.

Behaviour:
- Reset (async assert, sync deassert use): phase=00, led=0, busy=0, in_ready=1, latched result=0, synchroniser/debounce state=0, debounced level=0.
- Button path:
  - 2-flop synchroniser on pb_next.
  - Counter clears whenever the synchronised level equals the debounced level.
  - Otherwise the counter increments; on reaching DEBOUNCE_CYCLES, the debounced level takes the new value and the counter clears.
  - press = one-cycle pulse on the debounced 0->1 edge.
  - Press latency from a clean pb_next rise = 2 + DEBOUNCE_CYCLES cycles.
  - Any bounce before the count completes restarts the count.
- Handshake:
  - in_ready is combinationally 1 only in IDLE.
  - Transfer occurs when in_valid & in_ready at a clock edge.
  - in_sum, in_carry and in_cout are latched on that edge.
  - in_valid outside IDLE is ignored (no transfer); the source must hold its data.
- FSM:
  - IDLE: led=0. On transfer, go to SUM; press is ignored.
  - SUM: led=latched sum. On press, go to CARRY.
  - CARRY: led={zero pad, cout, carry[CARRY_W-1:0]}, i.e. bit CARRY_W = cout, upper bits 0. On press, go to IDLE.
- Outputs are registered: led and phase update on the same edge as the state change, so led reflects the new page 1 cycle after the transfer/press edge.
- Simultaneous events:
  - Transfer and press on the same cycle in IDLE: transfer wins and state goes to SUM; that press is consumed, not carried over.
  - A press while the button is held does not repeat; a release then new press is required.
- Reset mid-operation: immediately returns to IDLE with led=0; a pending press or debounce count is discarded.
- Phase encoding 11 is unreachable; if entered, go to IDLE next cycle.

Optional Feature:
- Macro: AUTO_ADV_EN.
- Defined:
  - A dwell counter clears on entry to SUM or CARRY and increments each cycle in those pages.
  - When it reaches AUTO_CYCLES-1, the page advances exactly as if a press occurred (SUM->CARRY, CARRY->IDLE).
  - A real press also advances and clears the counter.
  - The counter is held at 0 in IDLE.
- Not defined: no dwell counter; pages advance only on press.

Test Plan (DEBOUNCE_CYCLES=4, AUTO_CYCLES=8 at bench):
- Reset: assert rst_n=0 mid-cycle -> led=00000000, phase=00, in_ready=1, busy=0 immediately.
- Transfer: in_valid=1, in_sum=8'b1010_0110, in_carry=6'b011001, in_cout=1 -> one-cycle transfer; next cycle phase=01, led=10100110, in_ready=0.
- Debounced press: clean pb_next rise in SUM -> phase=10 and led=01011001 exactly 2+4+1 cycles after the rise. A second press -> phase=00, led=0.
- Bounce rejection: pb_next toggling every 2 cycles for 20 cycles, then released -> no page change. In_valid pulses during SUM -> no transfer; led unchanged.
- Same-cycle collision: in IDLE, arrange press pulse on the transfer edge -> phase=01, stays in SUM; a later press goes to CARRY. Reset asserted while in CARRY -> IDLE at once.
- AUTO_ADV_EN defined: transfer with no button activity -> SUM for 8 cycles, CARRY for 8 cycles, then IDLE. Without the macro -> stays in SUM indefinitely.

Source files
------------

// File: rtl/adder_result_presenter.sv
// Presents one adder result (sum, then carry vector + carry-out) on the board LEDs,
// paged by a debounced pushbutton. Define AUTO_ADV_EN to also advance pages on a dwell timer.
module adder_result_presenter #(
  parameter int SUM_W           = 8,
  parameter int CARRY_W         = 6,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int AUTO_CYCLES     = 1000000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SUM_W-1:0]   in_sum,
  input  logic [CARRY_W-1:0] in_carry,
  input  logic               in_cout,
  input  logic               pb_next,
  output logic [SUM_W-1:0]   led,
  output logic [1:0]         phase,
  output logic               busy
);

  if (CARRY_W > SUM_W - 1 || DEBOUNCE_CYCLES < 1 || AUTO_CYCLES < 1) begin : g_bad_params
    $error("adder_result_presenter: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    PH_IDLE    = 2'b00,
    PH_SUM     = 2'b01,
    PH_CARRY   = 2'b10,
    PH_ILLEGAL = 2'b11
  } phase_t;

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

  // ---------------------------------------------------------------- button path
  logic            sync1, sync2, deb, press;
  logic [DB_W-1:0] db_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      deb    <= 1'b0;
      press  <= 1'b0;
      db_cnt <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values, so the
      // synchroniser really is two stages regardless of statement order.
      sync1 <= pb_next;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == deb) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        deb    <= sync2;
        db_cnt <= '0;
        press  <= sync2;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------- page FSM
  phase_t             state_q, state_d;
  logic [SUM_W-1:0]   sum_q, led_q, led_d;
  logic [CARRY_W-1:0] carry_q;
  logic               cout_q;
  logic               xfer, advance;

  assign in_ready = (state_q == PH_IDLE);
  assign xfer     = in_valid & in_ready;

`ifdef AUTO_ADV_EN
  localparam int DW_W = (AUTO_CYCLES > 1) ? $clog2(AUTO_CYCLES) : 1;
  logic [DW_W-1:0] dwell_q;

  assign advance = press | (dwell_q == DW_W'(AUTO_CYCLES - 1));

  // Any page change (including a real press) restarts the dwell; IDLE pins it at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell_q <= '0;
    end else if (state_d != state_q || state_q == PH_IDLE) begin
      dwell_q <= '0;
    end else begin
      dwell_q <= dwell_q + 1'b1;
    end
  end
`else
  assign advance = press;
`endif

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d = state_q;
    led_d   = '0;
    case (state_q)
      PH_IDLE:  if (xfer)    state_d = PH_SUM;
      PH_SUM:   if (advance) state_d = PH_CARRY;
      PH_CARRY: if (advance) state_d = PH_IDLE;
      default:               state_d = PH_IDLE;
    endcase
    // LEDs are computed for the page being entered so they update with the phase.
    case (state_d)
      PH_SUM:   led_d = xfer ? in_sum : sum_q;
      PH_CARRY: begin
        led_d[CARRY_W-1:0] = carry_q;
        led_d[CARRY_W]     = cout_q;
      end
      default:  led_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PH_IDLE;
      led_q   <= '0;
      // NOTE: the result holding register is reset too; it is a few flops, not a RAM,
      // and a defined value keeps the CARRY page deterministic after reset.
      sum_q   <= '0;
      carry_q <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      led_q   <= led_d;
      if (xfer) begin
        sum_q   <= in_sum;
        carry_q <= in_carry;
        cout_q  <= in_cout;
      end
    end
  end

  assign led   = led_q;
  assign phase = state_q;
  assign busy  = (state_q != PH_IDLE);

endmodule
